// File: rtl/latch_bank_wr_arbiter.sv
// Round-robin write controller for a bank of level-sensitive latches.
// Each write is serialised and phased setup -> open -> hold around the latch enable.
module latch_bank_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 2,
  parameter int unsigned OPEN_CYC = 1,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  input  logic [NREQ*AW-1:0]      waddr,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [DEPTH-1:0]        lat_en,
  output logic [DW-1:0]           lat_d
);

  localparam int unsigned GW     = $clog2(NREQ);
  localparam int unsigned MaxCyc = (OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC;
  localparam int unsigned CW     = $clog2(MaxCyc + 1);

  typedef enum logic [1:0] {StIdle, StSetup, StOpen, StHold} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic [DEPTH-1:0] lat_en_q, lat_en_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [DW-1:0]   wdata_arr [NREQ];
  logic [AW-1:0]   waddr_arr [NREQ];
  logic            found;
  logic [GW-1:0]   win;
  logic [GW-1:0]   idx;
  logic            addr_oor;
  logic            last_hold;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign wdata_arr[g] = wdata[g*DW +: DW];
    assign waddr_arr[g] = waddr[g*AW +: AW];
  end

  assign addr_oor = 32'(addr_q) >= DEPTH;

  // First set request searching cyclically from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = GW'((32'(rr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    lat_d_d  = lat_d_q;
    lat_en_d = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = win;
          lat_d_d = wdata_arr[win];
          addr_d  = waddr_arr[win];
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d  = StOpen;
        cnt_d    = '0;
        lat_en_d = addr_oor ? '0 : (DEPTH'(1) << addr_q);
      end
      StOpen: begin
        if (cnt_q == CW'(OPEN_CYC - 1)) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          lat_en_d = lat_en_q;
        end
      end
      StHold: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          rr_d    = GW'((32'(grant_q) + 1) % NREQ);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so pulses are armed on the edge entering the final hold cycle.
    busy_d    = (state_d != StIdle);
    last_hold = (state_d == StHold) && (cnt_d == CW'(HOLD_CYC - 1));
    ack_d     = last_hold ? (NREQ'(1) << grant_d) : '0;
    err_d     = last_hold && addr_oor;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign lat_en   = lat_en_q;
  assign lat_d    = lat_d_q;

endmodule

// File: tb/tb_latch_bank_wr_arbiter.sv
// Bench for latch_bank_wr_arbiter: three configurations share stimulus and are
// checked cycle by cycle against a transaction-timeline model.
module tb_latch_bank_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  waddr = '0;

  logic [3:0] ack_0, ack_1, ack_2;
  logic       err_0, err_1, err_2;
  logic       busy_0, busy_1, busy_2;
  logic [1:0] gid_0, gid_1, gid_2;
  logic [3:0] len_0, len_2;
  logic [2:0] len_1;
  logic [7:0] ld_0, ld_1, ld_2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  latch_bank_wr_arbiter u_dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr), .ack(ack_0),
    .err(err_0), .busy(busy_0), .grant_id(gid_0), .lat_en(len_0), .lat_d(ld_0)
  );

  latch_bank_wr_arbiter #(.DEPTH(3)) u_oor (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr), .ack(ack_1),
    .err(err_1), .busy(busy_1), .grant_id(gid_1), .lat_en(len_1), .lat_d(ld_1)
  );

  latch_bank_wr_arbiter #(.OPEN_CYC(3), .HOLD_CYC(2)) u_tim (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr), .ack(ack_2),
    .err(err_2), .busy(busy_2), .grant_id(gid_2), .lat_en(len_2), .lat_d(ld_2)
  );

  logic [19:0] obs [3];
  assign obs[0] = {ack_0, err_0, busy_0, gid_0, len_0, ld_0};
  assign obs[1] = {ack_1, err_1, busy_1, gid_1, 1'b0, len_1, ld_1};
  assign obs[2] = {ack_2, err_2, busy_2, gid_2, len_2, ld_2};

  // Model: a transaction is a timeline counted in cycles since its grant edge.
  int       m_open  [3] = '{1, 1, 3};
  int       m_hold  [3] = '{1, 1, 2};
  int       m_depth [3] = '{4, 3, 4};
  bit       m_act   [3];
  int       m_pos   [3];
  int       m_gid   [3];
  int       m_rr    [3];
  int       m_addr  [3];
  logic [7:0] m_data [3];

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (!rst) begin
        m_act[d] = 0; m_pos[d] = 0; m_gid[d] = 0; m_rr[d] = 0; m_addr[d] = 0; m_data[d] = 0;
      end else if (m_act[d]) begin
        if (m_pos[d] == 1 + m_open[d] + m_hold[d]) begin
          m_act[d] = 0;
          m_rr[d]  = (m_gid[d] + 1) % 4;
        end else begin
          m_pos[d]++;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          int w;
          w = (m_rr[d] + k) % 4;
          if (!m_act[d] && req[w]) begin
            m_act[d]  = 1;
            m_pos[d]  = 1;
            m_gid[d]  = w;
            m_data[d] = wdata[w*8 +: 8];
            m_addr[d] = int'(waddr[w*2 +: 2]);
          end
        end
      end
    end
  endtask

  function automatic logic [19:0] expect_of(int d);
    logic [3:0] a;
    logic [3:0] le;
    logic       e;
    bit         last;
    last = m_act[d] && (m_pos[d] == 1 + m_open[d] + m_hold[d]);
    a    = last ? 4'(1 << m_gid[d]) : 4'd0;
    e    = last && (m_addr[d] >= m_depth[d]);
    le   = (m_act[d] && m_pos[d] >= 2 && m_pos[d] <= 1 + m_open[d] && m_addr[d] < m_depth[d])
           ? 4'(1 << m_addr[d]) : 4'd0;
    return {a, e, m_act[d], 2'(m_gid[d]), le, m_data[d]};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'hF;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (obs[d] !== 20'd0 || obs[d] !== expect_of(d)) begin
        miscompares++;
        $display("FAIL reset dut%0d got %h want %h", d, obs[d], expect_of(d));
      end
    end
    rst = 1'b1;
    req = '0;
  endtask

  task automatic test_single_write();
    do_reset();
    wdata = $urandom;
    wdata[7:0] = 8'hA5;
    waddr = 8'($urandom);
    waddr[1:0] = 2'd2;
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = '0;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL single dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
      vectors++;
      if ((c == 1 && (ld_0 !== 8'hA5 || busy_0 !== 1'b1)) ||
          (c == 2 && len_0 !== 4'b0100) || (c != 2 && len_0 !== 4'b0000) ||
          (c == 3 && (ack_0 !== 4'b0001 || err_0 !== 1'b0)) || (c == 4 && busy_0 !== 1'b0)) begin
        miscompares++;
        $display("FAIL single_direct c%0d got ld=%h en=%b ack=%b busy=%b", c, ld_0, len_0, ack_0,
                 busy_0);
      end
    end
  endtask

  task automatic test_all_four();
    int ids [$];
    int cyc [$];
    do_reset();
    wdata = $urandom;
    waddr = 8'($urandom);
    req = 4'hF;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL all_four dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
      for (int i = 0; i < 4; i++) if (ack_0[i]) begin ids.push_back(i); cyc.push_back(c); end
    end
    vectors++;
    if (ids.size() != 5) begin
      miscompares++;
      $display("FAIL all_four_count got %0d acks want 5", ids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (ids[i] != i % 4 || cyc[i] != 3 + 4 * i) begin
          miscompares++;
          $display("FAIL all_four_order #%0d got id%0d@%0d want id%0d@%0d", i, ids[i], cyc[i],
                   i % 4, 3 + 4 * i);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int ids [$];
    do_reset();
    wdata = $urandom;
    waddr = 8'($urandom);
    req = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      tick();
      req = 4'b0101;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL fairness dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
      for (int i = 0; i < 4; i++) if (ack_0[i]) ids.push_back(i);
    end
    vectors++;
    if (ids.size() != 4 || ids[0] != 0 || ids[1] != 2 || ids[2] != 0 || ids[3] != 2) begin
      miscompares++;
      $display("FAIL fairness_order got %p want 0,2,0,2", ids);
    end
    req = '0;
  endtask

  task automatic test_oor();
    do_reset();
    wdata = $urandom;
    waddr = 8'hFF;
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      req = '0;
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL oor dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
      vectors++;
      if (len_1 !== 3'b000 || (c == 3 && (ack_1 !== 4'b0001 || err_1 !== 1'b1)) ||
          (c != 3 && (ack_1 !== 4'b0000 || err_1 !== 1'b0))) begin
        miscompares++;
        $display("FAIL oor_direct c%0d got en=%b ack=%b err=%b", c, len_1, ack_1, err_1);
      end
    end
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    wdata = $urandom;
    waddr = 8'($urandom);
    req = 4'b0010;
    tick();
    tick();
    vectors++;
    if (len_0 !== 4'(1 << waddr[3:2]) || busy_0 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_open_pre got en=%b busy=%b want en=%b busy=1", len_0, busy_0,
               4'(1 << waddr[3:2]));
    end
    rst = 1'b0;
    req = 4'b0011;
    tick();
    vectors++;
    if (len_0 !== 4'b0 || busy_0 !== 1'b0 || ack_0 !== 4'b0) begin
      miscompares++;
      $display("FAIL mid_open_abort got en=%b busy=%b ack=%b want 0", len_0, busy_0, ack_0);
    end
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL mid_open dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
      if (c == 1) begin
        vectors++;
        if (gid_0 !== 2'd0) begin
          miscompares++;
          $display("FAIL mid_open_first got grant %0d want 0", gid_0);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_timing();
    int open_cnt = 0;
    int acks [$];
    do_reset();
    wdata = $urandom;
    waddr = 8'($urandom);
    req = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL timing dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
      if (c <= 7 && len_2 != 4'b0) open_cnt++;
      if (ack_2 != 4'b0) acks.push_back(c);
    end
    vectors++;
    if (open_cnt != 3 || acks.size() != 2 || acks[0] != 6 || acks[1] != 13) begin
      miscompares++;
      $display("FAIL timing_direct got open=%0d acks=%p want open=3 acks 6,13", open_cnt, acks);
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom);
      wdata = $urandom;
      waddr = 8'($urandom);
      rst   = ($urandom_range(0, 49) != 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        vectors++;
        if (obs[d] !== expect_of(d)) begin
          miscompares++;
          $display("FAIL random dut%0d c%0d got %h want %h", d, c, obs[d], expect_of(d));
        end
      end
    end
    rst = 1'b1;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_all_four();
    test_fairness();
    test_oor();
    test_reset_mid_open();
    test_timing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
